// File: rtl/uart_tx_gen_pkg.sv
// rtl/uart_tx_gen_pkg.sv - shared types and frame-format helpers for the UART transmitter
package uart_gen_pkg;

  localparam int WLEN_MIN   = 5;
  localparam int DATA_W_MAX = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

  function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data, input int wlen,
                                      input logic eps, input logic sp);
    logic x;
    x = 1'b0;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (i < wlen) x ^= data[i];
    end
    if (sp) return ~eps;
    return eps ? x : ~x;
  endfunction

  function automatic int stop_ticks(input logic stb, input int wlen, input int ovs);
    if (!stb) return ovs;
    if (wlen == WLEN_MIN) return ovs + ovs / 2;
    return 2 * ovs;
  endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// rtl/uart_tx_gen_if.sv - THR write port and FIFO status between register file and transmitter
interface uart_tx_gen_if #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16
);
  logic                            wr;
  logic [DATA_W-1:0]               din;
  logic                            full;
  logic                            fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  logic                            ovf;

  modport master (output wr, din, input full, fifo_empty, count, ovf);
  modport slave  (input wr, din, output full, fifo_empty, count, ovf);
endinterface

// File: rtl/uart_tx_gen_fifo.sv
// rtl/uart_tx_gen_fifo.sv - first-word-fall-through transmit FIFO with overflow pulse
module uart_sync_fifo #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_i,
  input  logic [DATA_W-1:0]               din_i,
  input  logic                            rd_i,
  output logic [DATA_W-1:0]               dout_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            ovf_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q;
  logic              push, pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop  = rd_i && !empty_o;
  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign push = wr_i && (!full_o || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= wr_i && !push;
    end
  end
endmodule

// File: rtl/uart_tx_gen.sv
// rtl/uart_tx_gen.sv - UART transmitter: baud generator, transmit FIFO and frame serializer
module uart_tx_gen
  import uart_gen_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int OVS        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] divisor_i,
  input  logic [3:0]       wlen_i,
  input  logic             pen_i,
  input  logic             eps_i,
  input  logic             sp_i,
  input  logic             stb_i,
  input  logic             brk_i,
  uart_tx_gen_if.slave     bus,
  output logic             tx_o,
  output logic             sreg_empty_o,
  output logic             baud_pulse_o
);
  localparam int TICK_W = $clog2(2*OVS+1);

  logic [DIV_W-1:0]  baud_cnt_q, baud_cnt_d, div_m1;
  logic              baud_q, baud_d;
  tx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d, stop_q, stop_d;
  logic [3:0]        bit_q, bit_d, wlen_q, wlen_d, wlen_eff;
  logic [DATA_W-1:0] shreg_q, shreg_d, head;
  logic              par_q, par_d, pen_q, pen_d, tx_q, tx_d;
  logic              pop, start_frame, bit_tx;

  uart_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_i    (bus.wr),
    .din_i   (bus.din),
    .rd_i    (pop),
    .dout_o  (head),
    .full_o  (bus.full),
    .empty_o (bus.fifo_empty),
    .count_o (bus.count),
    .ovf_o   (bus.ovf)
  );

  // divisor 0 freezes the counter, so the reload value is clamped to keep it sane.
  assign div_m1 = (divisor_i == '0) ? '0 : divisor_i - 1'b1;

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    baud_d     = 1'b0;
    if (divisor_i != '0) begin
      if (baud_cnt_q == '0) begin
        baud_d     = 1'b1;
        baud_cnt_d = div_m1;
      end else begin
        baud_cnt_d = baud_cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    wlen_eff = wlen_i;
    if (wlen_i < 4'(WLEN_MIN))     wlen_eff = 4'(WLEN_MIN);
    else if (wlen_i > 4'(DATA_W))  wlen_eff = 4'(DATA_W);
  end

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    pen_d       = pen_q;
    wlen_d      = wlen_q;
    stop_d      = stop_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: if (baud_q && !bus.fifo_empty) start_frame = 1'b1;
      START: if (baud_q) begin
        if (tick_q == TICK_W'(OVS-1)) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else tick_d = tick_q + 1'b1;
      end
      DATA: if (baud_q) begin
        if (tick_q == TICK_W'(OVS-1)) begin
          tick_d  = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 4'd1;
          if (bit_q == wlen_q - 4'd1) state_d = pen_q ? PARITY : STOP;
        end else tick_d = tick_q + 1'b1;
      end
      PARITY: if (baud_q) begin
        if (tick_q == TICK_W'(OVS-1)) begin
          tick_d  = '0;
          state_d = STOP;
        end else tick_d = tick_q + 1'b1;
      end
      STOP: if (baud_q) begin
        if (tick_q == stop_q - 1'b1) begin
          tick_d = '0;
          if (!bus.fifo_empty) start_frame = 1'b1;
          else state_d = IDLE;
        end else tick_d = tick_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Frame format is captured at pop time so register writes mid-frame hit the next frame.
    if (start_frame) begin
      pop     = 1'b1;
      state_d = START;
      tick_d  = '0;
      shreg_d = head;
      wlen_d  = wlen_eff;
      pen_d   = pen_i;
      par_d   = parity_bit(DATA_W_MAX'(head), int'(wlen_eff), eps_i, sp_i);
      stop_d  = TICK_W'(stop_ticks(stb_i, int'(wlen_eff), OVS));
    end
    case (state_d)
      START:   bit_tx = 1'b0;
      DATA:    bit_tx = shreg_d[0];
      PARITY:  bit_tx = par_d;
      default: bit_tx = 1'b1;
    endcase
    tx_d = brk_i ? 1'b0 : bit_tx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt_q <= div_m1;
      baud_q     <= 1'b0;
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      pen_q      <= 1'b0;
      wlen_q     <= 4'(WLEN_MIN);
      stop_q     <= TICK_W'(OVS);
      tx_q       <= 1'b1;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      baud_q     <= baud_d;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      pen_q      <= pen_d;
      wlen_q     <= wlen_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
    end
  end

  assign tx_o         = tx_q;
  assign sreg_empty_o = (state_q == IDLE);
  assign baud_pulse_o = baud_q;
endmodule

// File: doc/uart_tx_gen.md
Name: uart_tx_gen

Overview:
Parametrised next-generation UART transmitter for the 16550-style UART top. It combines a runtime-programmable baud generator, a transmit FIFO of configurable depth, and a frame serializer. The frame format is configurable at runtime: word length 5..DATA_W, none/odd/even/stick parity, 1/1.5/2 stop bits, and break. It plugs in behind the register file, which drives divisor and line-control fields and pushes THR writes.

Parameters:
DATA_W, 9, maximum data bits per frame (legal range 5..9)
FIFO_DEPTH, 16, transmit FIFO entries (power of two, >=2)
DIV_W, 16, baud divisor width
OVS, 16, baud pulses per bit time (oversampling factor)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
divisor  in  DIV_W  clocks per baud_pulse; 0 stalls the baud generator
wlen  in  4  data bits per frame; <5 is treated as 5, >DATA_W is treated as DATA_W
pen  in  1  parity enable
eps  in  1  even parity select
sp  in  1  stick parity
stb  in  1  0 = 1 stop bit; 1 = 1.5 stop bits when wlen==5, else 2
brk  in  1  force tx low
wr  in  1  push din into FIFO
din  in  DATA_W  write data (only low wlen bits are sent)
full  out  1  FIFO full
fifo_empty  out  1  FIFO empty
count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
ovf  out  1  one-cycle pulse when a write is dropped
tx  out  1  serial output
sreg_empty  out  1  serializer idle (state IDLE)
baud_pulse  out  1  one-cycle OVS tick

Behaviour:
- Reset: tx=1, sreg_empty=1, full=0, fifo_empty=1, count=0, ovf=0, baud_pulse=0. State=IDLE. Baud counter loads divisor-1. Pointers cleared. Reset mid-frame aborts the frame; tx=1 on the cycle after rst is sampled.
- Baud generator: down-counter. When it reaches 0 it asserts baud_pulse for one cycle and reloads divisor-1, giving a period of exactly divisor clocks. A divisor change takes effect at the next reload. divisor=0 produces no pulses and holds the counter.
- FIFO push: write occurs on wr && (!full || pop same cycle). With a simultaneous push and pop while full, the write is accepted and count is unchanged. Otherwise wr while full drops data and pulses ovf on the next cycle. count is updated the cycle after the event.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on baud_pulse with !fifo_empty, pop the head into the shift register. Latch wlen, pen, eps, sp, stb for the whole frame (later changes apply to the next frame). Go to START; tx=0 from the next cycle.
  - START: OVS baud_pulses, then go to DATA.
  - DATA: send LSB first, OVS pulses per bit, wlen bits, then go to PARITY if pen, else STOP.
  - PARITY: one bit time. Parity bit rules:
    - sp=0, eps=1: XOR of the sent bits (even).
    - sp=0, eps=0: inverted XOR (odd).
    - sp=1: bit = ~eps.
  - STOP: tx=1 for OVS, 1.5*OVS, or 2*OVS pulses. Then, if the FIFO is non-empty, pop and go directly to START with no idle gap (back-to-back frames); otherwise go to IDLE.
- Tick counter width: $clog2(2*OVS+1).
- brk=1 forces tx=0 combinationally-registered (next cycle) but does not stall the FSM; the frame continues underneath.
- sreg_empty=1 only in IDLE. Transmitter fully empty is sreg_empty && fifo_empty.

Decomposition:
- Package uart_gen_pkg:
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - parity_bit(data, wlen, eps, sp) function
  - stop_ticks(stb, wlen, OVS) function
  - WLEN_MIN=5 constant
- One sub-module: uart_sync_fifo (DATA_W, FIFO_DEPTH; wr/rd/full/empty/count/ovf).
- Baud generator and FSM stay in the top.

Test Plan:
1. divisor=8, no writes -> baud_pulse exactly every 8 clks. Write divisor=0 -> pulses stop after the current period. Restore 8 -> pulses resume.
2. divisor=1, wlen=8, pen=0, stb=0, write 0xA5 -> tx: 0 for 16 clks, then 1,0,1,0,0,1,0,1 (16 clks each), then 1 for 16 clks. Frame is 160 clks; sreg_empty returns to 1.
3. divisor=1, wlen=5, pen=1, eps=0, sp=0, stb=1, write 0xF0 -> data bits 0,0,0,0,1; odd parity bit 0; stop high 24 clks. Total frame 16*7+24=136 clks.
4. divisor=0, 17 writes (0x00..0x10) -> full after the 16th, count=16, 17th dropped with a single ovf pulse. Set divisor=1 -> 16 back-to-back frames carry 0x00..0x0F with no idle gap, and count decrements once per frame.
5. DATA_W=9, wlen=9, pen=1, sp=1, eps=1, write 0x1FF -> 9 ones, then parity bit 0, then 1 stop. Then brk=1 mid-data -> tx=0 until brk=0, and the frame end time is unchanged.
6. Assert rst for 1 clk mid-DATA with 3 entries queued -> tx=1, count=0, sreg_empty=1 next cycle. No further frames without new writes.
